seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment display driver, downstream of the priority-encoder/segment-decode stage.
- Collects per-digit 8-bit active-low segment patterns through a valid/ready write port into a back buffer.
- Commits the whole set atomically at a frame boundary, then scans the digits one at a time with a blanking gap to suppress ghosting.

Parameters:
- NDIG, 8, number of digits scanned (1..8).
- DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK, 16, leading cycles of each slot with all anodes off (0 <= BLANK < DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  write/commit request.
- in_ready  out  1  block can accept a beat.
- in_commit  in  1  beat also requests a back-to-front swap.
- in_idx  in  3  target digit index.
- in_seg  in  8  segment pattern, active-low, same bit order as the upstream decoder.
- an  out  NDIG  digit enables, active-low, at most one low.
- seg_out  out  8  segment drive, active-low.
- frame_tick  out  1  one-cycle pulse at each frame end.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_n is low, asynchronously and immediately:
  - all back and front entries = 8'hFF; cnt = 0; digit = 0; pending = 0.
  - an = all ones; seg_out = 8'hFF; in_ready = 1; frame_tick = 0.
- Reset asserted mid-frame or mid-commit discards everything. The first slot after release is digit 0 with cnt = 0.
- Scan counters:
  - cnt counts 0..DIV-1, width clog2(DIV), wraps to 0.
  - On the cnt == DIV-1 cycle, digit advances; digit NDIG-1 wraps to 0.
  - Frame end = the cycle with cnt == DIV-1 and digit == NDIG-1.
- Outputs are registered from the current cnt/digit, so they lag the counters by one cycle.
  - If cnt < BLANK: an = all ones, seg_out = 8'hFF.
  - Otherwise: an = ~(1 << digit), seg_out = front[digit].
- frame_tick: registered, high for exactly the one cycle after each frame-end cycle. It pulses whether or not a swap occurs.
- Write beat (in_valid & in_ready):
  - back[in_idx] <= in_seg.
  - in_idx >= NDIG: data is dropped, but the beat still completes (and still commits if in_commit).
  - A beat is held until accepted; the source keeps fields stable while in_ready is low.
- Commit beat (accepted with in_commit = 1):
  - Its data is written as in a write beat.
  - pending <= 1; in_ready goes low from the next cycle.
- Swap:
  - Occurs on the first frame end at which pending was already 1 at the start of that cycle.
  - front <= back (all entries); pending <= 0.
  - in_ready returns high the cycle after the swap.
- Simultaneous commit and frame end: a commit accepted on a frame-end cycle does not swap at that edge. It swaps at the following frame end.
- While pending, back is frozen, since in_ready is low and no writes are possible.
- front only ever changes at a swap or reset. Displayed data never tears within a frame.
- Outside blanking, exactly one anode is low. BLANK = 0 means no gap.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release.
  - During reset: an = 4'b1111, seg_out = 8'hFF, in_ready = 1.
  - Next: digit 0 slot shows an = 4'b1111 (blank), then an = 4'b1110 with seg_out = 8'hFF.
- Write and commit, with NDIG = 4, DIV = 4, BLANK = 1:
  - Stimulus: write idx 0..3 = 8'h02, 8'h9E, 8'h24, 8'h0C, the last beat with in_commit.
  - Required: in_ready low until the frame end, then one frame_tick.
  - Next frame: per slot, 1 blank cycle, then 3 cycles of an = 1110/1101/1011/0111 with seg_out = 02/9E/24/0C.
- Atomicity: write idx 1 = 8'h40 without commit.
  - Display stays 8'h9E on digit 1 for 3 further frames.
  - Then commit: 8'h40 appears only from the next frame start.
- Commit on a frame-end cycle: drive the commit so it is accepted exactly at cnt = 3, digit = 3.
  - No swap at that edge.
  - Swap and in_ready rise one frame (16 cycles) later.
- Out-of-range index with NDIG = 4: write idx 5 = 8'h00 with commit.
  - Beat accepted and swap occurs.
  - All displayed patterns are unchanged; no anode beyond bit 3 exists.
- Reset mid-commit: pull rst_n low while pending = 1.
  - Outputs immediately an = all ones, seg_out = 8'hFF.
  - After release: in_ready = 1 and all digits display 8'hFF.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: double-buffered digit patterns,
// atomic back-to-front swap at frame end, blanking gap at the start of every slot.
module seg_scan_driver #(
   parameter int NDIG  = 8,
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_commit,
   input  logic [2:0]      in_idx,
   input  logic [7:0]      in_seg,
   output logic [NDIG-1:0] an,
   output logic [7:0]      seg_out,
   output logic            frame_tick
);

   localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0]   BLANK_C = CW'(BLANK);
   localparam logic [2:0]      DIG_MAX = 3'(NDIG - 1);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      digit_q, digit_d;
   logic            pending_q, pending_d;
   logic [7:0]      back_q  [NDIG];
   logic [7:0]      back_d  [NDIG];
   logic [7:0]      front_q [NDIG];
   logic [7:0]      front_d [NDIG];
   logic [NDIG-1:0] an_q, an_d;
   logic [7:0]      seg_q, seg_d;
   logic            tick_q, tick_d;

   logic            frame_end_s;
   logic            accept_s;
   logic            swap_s;
   logic [7:0]      cur_seg_s;

   assign in_ready   = ~pending_q;
   assign an         = an_q;
   assign seg_out    = seg_q;
   assign frame_tick = tick_q;

   // Next-state logic for scan counters, buffers, pending flag and output drive
   always_comb begin
      cnt_d       = cnt_q;
      digit_d     = digit_q;
      pending_d   = pending_q;
      back_d      = back_q;
      front_d     = front_q;
      an_d        = {NDIG{1'b1}};
      seg_d       = 8'hFF;
      cur_seg_s   = 8'hFF;

      frame_end_s = (cnt_q == CNT_MAX) && (digit_q == DIG_MAX);
      accept_s    = in_valid && !pending_q;
      // pending is sampled before this edge, so a commit landing on a frame end waits a frame
      swap_s      = pending_q && frame_end_s;
      tick_d      = frame_end_s;

      if (cnt_q == CNT_MAX) begin
         cnt_d = {CW{1'b0}};
         if (digit_q == DIG_MAX) begin
            digit_d = 3'd0;
         end else begin
            digit_d = digit_q + 3'd1;
         end
      end else begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end

      if (accept_s) begin
         for (int i = 0; i < NDIG; i++) begin
            if (in_idx == 3'(i)) begin
               back_d[i] = in_seg;
            end else begin
               back_d[i] = back_q[i];
            end
         end
      end else begin
         back_d = back_q;
      end

      if (swap_s) begin
         front_d   = back_q;
         pending_d = 1'b0;
      end else if (accept_s && in_commit) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      for (int i = 0; i < NDIG; i++) begin
         if (digit_q == 3'(i)) begin
            cur_seg_s = front_q[i];
         end else begin
            cur_seg_s = cur_seg_s;
         end
      end

      if (cnt_q < BLANK_C) begin
         an_d  = {NDIG{1'b1}};
         seg_d = 8'hFF;
      end else begin
         an_d  = ~(NDIG'(1) << digit_q);
         seg_d = cur_seg_s;
      end
   end

   // State and output registers; reset blanks the display and discards any pending commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= {CW{1'b0}};
         digit_q   <= 3'd0;
         pending_q <= 1'b0;
         for (int i = 0; i < NDIG; i++) begin
            back_q[i]  <= 8'hFF;
            front_q[i] <= 8'hFF;
         end
         an_q      <= {NDIG{1'b1}};
         seg_q     <= 8'hFF;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         pending_q <= pending_d;
         for (int i = 0; i < NDIG; i++) begin
            back_q[i]  <= back_d[i];
            front_q[i] <= front_d[i];
         end
         an_q      <= an_d;
         seg_q     <= seg_d;
         tick_q    <= tick_d;
      end
   end

endmodule
